// File: rtl/jt7759_rom_arb_if.sv
// jt7759_rom_arb_if
//   Bundle for the two private client ROM ports and the shared downstream ROM port.
//   slave  : arbiter view (takes client requests and ROM data, drives client data/ok,
//            downstream request and the timeout pulse)
//   master : environment view (clients + downstream memory)
//   Signals per client i (0/1): cs<i>, addr<i>, flush<i>, data<i>, ok<i>
//   Downstream: rom_cs, rom_addr, rom_data, rom_ok; status: timeout_err
interface jt7759_rom_arb_if #(
   parameter int AW = 17,
   parameter int DW = 8
);
   logic          cs0;
   logic [AW-1:0] addr0;
   logic          flush0;
   logic [DW-1:0] data0;
   logic          ok0;

   logic          cs1;
   logic [AW-1:0] addr1;
   logic          flush1;
   logic [DW-1:0] data1;
   logic          ok1;

   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          rom_ok;
   logic          timeout_err;

   modport slave (
      input  cs0, addr0, flush0, cs1, addr1, flush1, rom_data, rom_ok,
      output data0, ok0, data1, ok1, rom_cs, rom_addr, timeout_err
   );

   modport master (
      output cs0, addr0, flush0, cs1, addr1, flush1, rom_data, rom_ok,
      input  data0, ok0, data1, ok1, rom_cs, rom_addr, timeout_err
   );
endinterface

// File: rtl/jt7759_rom_arb.sv
// jt7759_rom_arb
//   Shares one downstream sample-ROM port between two ROM clients. Each client has a
//   one-entry cache (valid/address/data); misses are arbitrated round-robin and fetched
//   through the shared port. Abandoned, redirected or stalled fetches are aborted.
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - jt7759_rom_arb_if.slave (client ports 0/1, downstream ROM port, timeout_err)
//
//   state | meaning
//   IDLE  | rom_cs low; pick a client with a cache miss, launch its fetch
//   BUSY  | rom_cs high for the granted client; wait for a settled rom_ok,
//         | abort on client cs/addr change, give up after 2^TOW-1 cycles
module jt7759_rom_arb #(
   parameter int AW  = 17,
   parameter int DW  = 8,
   parameter int TOW = 10
) (
   input  logic            clk,
   input  logic            rst,
   jt7759_rom_arb_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   state_t         state_q, state_d;
   logic           gnt_q, gnt_d;
   logic           last_q, last_d;
   logic           settle_q, settle_d;
   logic [TOW-1:0] cnt_q, cnt_d;
   logic           rom_cs_q, rom_cs_d;
   logic [AW-1:0]  rom_addr_q, rom_addr_d;
   logic           terr_q, terr_d;
   logic [1:0]     v_q, v_d;
   logic [AW-1:0]  ca_q [2];
   logic [AW-1:0]  ca_d [2];
   logic [DW-1:0]  cd_q [2];
   logic [DW-1:0]  cd_d [2];

   logic [1:0]     cs_w, flush_w, ok_w, need_w;
   logic [AW-1:0]  addr_w [2];
   logic           win_w;
   logic           gcs_w;
   logic [AW-1:0]  gaddr_w;
   logic [TOW-1:0] cnt_inc_w;

   assign cs_w      = {bus.cs1, bus.cs0};
   assign flush_w   = {bus.flush1, bus.flush0};
   assign addr_w[0] = bus.addr0;
   assign addr_w[1] = bus.addr1;

   assign ok_w[0] = cs_w[0] & v_q[0] & (ca_q[0] == addr_w[0]);
   assign ok_w[1] = cs_w[1] & v_q[1] & (ca_q[1] == addr_w[1]);
   assign need_w  = cs_w & ~ok_w;

   // With both clients missing, the one not served last wins.
   assign win_w   = (&need_w) ? ~last_q : need_w[1];

   assign gcs_w   = cs_w[gnt_q];
   assign gaddr_w = addr_w[gnt_q];

   // Timeout fires on the cycle the counter would reach all-ones, so rom_cs is held
   // for exactly 2^TOW-1 cycles and the counter never wraps.
   assign cnt_inc_w = cnt_q + TOW'(1);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      settle_d   = settle_q;
      cnt_d      = cnt_q;
      rom_cs_d   = rom_cs_q;
      rom_addr_d = rom_addr_q;
      terr_d     = 1'b0;
      v_d        = v_q;
      ca_d       = ca_q;
      cd_d       = cd_q;

      case (state_q)
         ST_IDLE: begin
            rom_cs_d = 1'b0;
            if (|need_w) begin
               gnt_d      = win_w;
               rom_addr_d = addr_w[win_w];
               rom_cs_d   = 1'b1;
               settle_d   = 1'b0;
               cnt_d      = '0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // rom_ok in the first BUSY cycle may still belong to the previous address.
            settle_d = 1'b1;
            cnt_d    = cnt_inc_w;
            if (!gcs_w || (gaddr_w != rom_addr_q)) begin
               rom_cs_d = 1'b0;
               state_d  = ST_IDLE;
            end else if (bus.rom_ok && settle_q) begin
               cd_d[gnt_q] = bus.rom_data;
               ca_d[gnt_q] = rom_addr_q;
               v_d[gnt_q]  = 1'b1;
               rom_cs_d    = 1'b0;
               last_d      = gnt_q;
               state_d     = ST_IDLE;
            end else if (cnt_inc_w == '1) begin
               rom_cs_d = 1'b0;
               terr_d   = 1'b1;
               last_d   = gnt_q;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Flush beats a completion landing in the same cycle.
      v_d = v_d & ~flush_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 1'b0;
         last_q     <= 1'b1;
         settle_q   <= 1'b0;
         cnt_q      <= '0;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= '0;
         terr_q     <= 1'b0;
         v_q        <= '0;
         ca_q[0]    <= '0;
         ca_q[1]    <= '0;
         cd_q[0]    <= '0;
         cd_q[1]    <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         settle_q   <= settle_d;
         cnt_q      <= cnt_d;
         rom_cs_q   <= rom_cs_d;
         rom_addr_q <= rom_addr_d;
         terr_q     <= terr_d;
         v_q        <= v_d;
         ca_q       <= ca_d;
         cd_q       <= cd_d;
      end
   end

   assign bus.data0       = cd_q[0];
   assign bus.data1       = cd_q[1];
   assign bus.ok0         = ok_w[0];
   assign bus.ok1         = ok_w[1];
   assign bus.rom_cs      = rom_cs_q;
   assign bus.rom_addr    = rom_addr_q;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_jt7759_rom_arb.sv
// tb_jt7759_rom_arb
//   Directed scenarios plus a randomized run. The reference for returned data is a fixed
//   ROM content function of the full address; timing expectations come from the stated
//   latency, arbitration and timeout rules.
module tb_jt7759_rom_arb;
   localparam int AW  = 17;
   localparam int DW  = 8;
   localparam int TOW = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   jt7759_rom_arb_if #(.AW(AW), .DW(DW)) bus ();

   jt7759_rom_arb #(.AW(AW), .DW(DW), .TOW(TOW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
      return a[7:0] ^ {a[16:13], a[12:9]} ^ 8'hA5;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus.cs0    = 1'b0;
      bus.addr0  = '0;
      bus.flush0 = 1'b0;
      bus.cs1    = 1'b0;
      bus.addr1  = '0;
      bus.flush1 = 1'b0;
      bus.rom_ok = 1'b0;
      bus.rom_data = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Waits (bounded) for rom_cs, records the address, returns rom_ok/data after lat cycles.
   // Returns at the start of the cycle following the one that presented rom_ok.
   task automatic serve(input logic [DW-1:0] d, input int lat,
                        output logic [AW-1:0] a, output bit seen, output int waited);
      seen   = 1'b0;
      a      = '0;
      waited = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         if (bus.rom_cs) seen = 1'b1;
         else begin
            tick();
            waited++;
         end
      end
      if (seen) begin
         a = bus.rom_addr;
         repeat (lat) tick();
         bus.rom_data = d;
         bus.rom_ok   = 1'b1;
         tick();
         bus.rom_ok   = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cs0 = 1'b1; bus.addr0 = '0; bus.flush0 = 1'b0;
      bus.cs1 = 1'b1; bus.addr1 = '0; bus.flush1 = 1'b0;
      bus.rom_ok = 1'b1; bus.rom_data = 8'hFF;
      tick();
      tick();
      n_checks++; if (bus.rom_cs !== 1'b0) begin n_errors++; $display("FAIL reset_rom_cs got %0h exp 0", bus.rom_cs); end
      n_checks++; if (bus.rom_addr !== '0) begin n_errors++; $display("FAIL reset_rom_addr got %0h exp 0", bus.rom_addr); end
      n_checks++; if (bus.ok0 !== 1'b0) begin n_errors++; $display("FAIL reset_ok0 got %0h exp 0", bus.ok0); end
      n_checks++; if (bus.ok1 !== 1'b0) begin n_errors++; $display("FAIL reset_ok1 got %0h exp 0", bus.ok1); end
      n_checks++; if (bus.timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_terr got %0h exp 0", bus.timeout_err); end
      n_checks++; if (bus.data0 !== '0) begin n_errors++; $display("FAIL reset_data0 got %0h exp 0", bus.data0); end
      do_reset();
   endtask

   task automatic test_single_fetch();
      do_reset();
      bus.cs0 = 1'b1; bus.addr0 = 17'h00005;
      tick();
      n_checks++; if (bus.rom_cs !== 1'b1) begin n_errors++; $display("FAIL single_cs_rise got %0h exp 1", bus.rom_cs); end
      n_checks++; if (bus.rom_addr !== 17'h00005) begin n_errors++; $display("FAIL single_rom_addr got %0h exp 5", bus.rom_addr); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if (bus.rom_cs !== 1'b1 || bus.ok0 !== 1'b0) begin n_errors++; $display("FAIL single_busy%0d got cs=%0h ok0=%0h exp cs=1 ok0=0", k, bus.rom_cs, bus.ok0); end
      end
      bus.rom_ok = 1'b1; bus.rom_data = 8'h5A;
      tick();
      bus.rom_ok = 1'b0;
      n_checks++; if (bus.ok0 !== 1'b1) begin n_errors++; $display("FAIL single_ok0 got %0h exp 1", bus.ok0); end
      n_checks++; if (bus.data0 !== 8'h5A) begin n_errors++; $display("FAIL single_data0 got %0h exp 5a", bus.data0); end
      n_checks++; if (bus.rom_cs !== 1'b0) begin n_errors++; $display("FAIL single_cs_fall got %0h exp 0", bus.rom_cs); end
      bus.cs0 = 1'b0;
      tick();
      bus.cs0 = 1'b1; bus.addr0 = 17'h00005;
      #1;
      n_checks++; if (bus.ok0 !== 1'b1) begin n_errors++; $display("FAIL single_hit_ok0 got %0h exp 1", bus.ok0); end
      tick();
      n_checks++; if (bus.rom_cs !== 1'b0) begin n_errors++; $display("FAIL single_hit_no_cs got %0h exp 0", bus.rom_cs); end
   endtask

   task automatic test_contention();
      logic [AW-1:0] a;
      bit            s;
      int            w;
      do_reset();
      bus.cs0 = 1'b1; bus.addr0 = 17'h00010;
      bus.cs1 = 1'b1; bus.addr1 = 17'h00020;
      serve(8'hA1, 1, a, s, w);
      n_checks++; if (!s || a !== 17'h00010) begin n_errors++; $display("FAIL cont_first got addr=%0h seen=%0d exp addr=10", a, s); end
      n_checks++; if (bus.ok0 !== 1'b1 || bus.data0 !== 8'hA1) begin n_errors++; $display("FAIL cont_data0 got ok=%0h d=%0h exp ok=1 d=a1", bus.ok0, bus.data0); end
      serve(8'hB2, 1, a, s, w);
      n_checks++; if (!s || a !== 17'h00020 || w != 1) begin n_errors++; $display("FAIL cont_second got addr=%0h gap=%0d exp addr=20 gap=1", a, w); end
      n_checks++; if (bus.ok1 !== 1'b1 || bus.data1 !== 8'hB2) begin n_errors++; $display("FAIL cont_data1 got ok=%0h d=%0h exp ok=1 d=b2", bus.ok1, bus.data1); end
      bus.addr0 = 17'h00011;
      bus.addr1 = 17'h00021;
      serve(8'hC3, 1, a, s, w);
      n_checks++; if (!s || a !== 17'h00011) begin n_errors++; $display("FAIL cont_rr_first got addr=%0h exp 11", a); end
      serve(8'hD4, 2, a, s, w);
      n_checks++; if (!s || a !== 17'h00021) begin n_errors++; $display("FAIL cont_rr_second got addr=%0h exp 21", a); end
      n_checks++; if (bus.ok0 !== 1'b1 || bus.data0 !== 8'hC3 || bus.ok1 !== 1'b1 || bus.data1 !== 8'hD4) begin n_errors++; $display("FAIL cont_rr_data got %0h/%0h exp c3/d4", bus.data0, bus.data1); end
   endtask

   task automatic test_abort();
      logic [AW-1:0] a;
      bit            s;
      int            w;
      do_reset();
      bus.cs0 = 1'b1; bus.addr0 = 17'h00100;
      tick();
      n_checks++; if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 17'h00100) begin n_errors++; $display("FAIL abort_start got cs=%0h addr=%0h exp cs=1 addr=100", bus.rom_cs, bus.rom_addr); end
      tick();
      bus.addr0 = 17'h00101;
      bus.rom_ok = 1'b1; bus.rom_data = 8'hEE;
      tick();
      bus.rom_ok = 1'b0;
      n_checks++; if (bus.rom_cs !== 1'b0) begin n_errors++; $display("FAIL abort_cs_drop got %0h exp 0", bus.rom_cs); end
      bus.addr0 = 17'h00100;
      #1;
      n_checks++; if (bus.ok0 !== 1'b0 || bus.data0 !== 8'h00) begin n_errors++; $display("FAIL abort_no_cache got ok=%0h d=%0h exp ok=0 d=0", bus.ok0, bus.data0); end
      bus.addr0 = 17'h00101;
      tick();
      n_checks++; if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 17'h00101) begin n_errors++; $display("FAIL abort_refetch got cs=%0h addr=%0h exp cs=1 addr=101", bus.rom_cs, bus.rom_addr); end
      serve(8'h77, 2, a, s, w);
      n_checks++; if (!s || bus.ok0 !== 1'b1 || bus.data0 !== 8'h77) begin n_errors++; $display("FAIL abort_final got ok=%0h d=%0h exp ok=1 d=77", bus.ok0, bus.data0); end
   endtask

   task automatic test_stale_ok();
      logic [AW-1:0] used;
      do_reset();
      bus.cs0 = 1'b1; bus.addr0 = 17'h00042;
      bus.rom_ok = 1'b1; bus.rom_data = 8'h10;
      tick();
      used = bus.rom_addr;
      n_checks++; if (bus.rom_cs !== 1'b1) begin n_errors++; $display("FAIL stale_cs got %0h exp 1", bus.rom_cs); end
      bus.rom_data = 8'h11;
      tick();
      n_checks++; if (bus.ok0 !== 1'b0) begin n_errors++; $display("FAIL stale_early_capture got ok0=%0h d=%0h exp ok0=0", bus.ok0, bus.data0); end
      bus.rom_data = 8'h12;
      tick();
      bus.rom_ok = 1'b0;
      n_checks++; if (bus.ok0 !== 1'b1 || bus.data0 !== 8'h12) begin n_errors++; $display("FAIL stale_capture got ok=%0h d=%0h exp ok=1 d=12", bus.ok0, bus.data0); end
      n_checks++; if (used !== 17'h00042) begin n_errors++; $display("FAIL stale_addr got %0h exp 42", used); end
   endtask

   task automatic test_timeout();
      int            high;
      bit            done;
      logic [AW-1:0] a;
      bit            s;
      int            w;
      do_reset();
      bus.cs0 = 1'b1; bus.addr0 = 17'h00055;
      bus.cs1 = 1'b1; bus.addr1 = 17'h00066;
      high = 0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         tick();
         if (bus.rom_cs) high++;
         else if (high > 0) done = 1'b1;
      end
      n_checks++; if (!done) begin n_errors++; $display("FAIL timeout_wait got no cs drop exp drop within 40 cycles"); end
      n_checks++; if (high != 15) begin n_errors++; $display("FAIL timeout_len got %0d exp 15", high); end
      n_checks++; if (bus.timeout_err !== 1'b1) begin n_errors++; $display("FAIL timeout_pulse got %0h exp 1", bus.timeout_err); end
      n_checks++; if (bus.ok0 !== 1'b0) begin n_errors++; $display("FAIL timeout_no_cache got %0h exp 0", bus.ok0); end
      tick();
      n_checks++; if (bus.timeout_err !== 1'b0) begin n_errors++; $display("FAIL timeout_single got %0h exp 0", bus.timeout_err); end
      n_checks++; if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 17'h00066) begin n_errors++; $display("FAIL timeout_next got cs=%0h addr=%0h exp cs=1 addr=66", bus.rom_cs, bus.rom_addr); end
      bus.cs0 = 1'b0;
      serve(8'h21, 1, a, s, w);
      n_checks++; if (!s || bus.ok1 !== 1'b1 || bus.data1 !== 8'h21) begin n_errors++; $display("FAIL timeout_serve1 got ok=%0h d=%0h exp ok=1 d=21", bus.ok1, bus.data1); end
   endtask

   task automatic test_flush_reset();
      logic [AW-1:0] a;
      bit            s;
      int            w;
      do_reset();
      bus.cs0 = 1'b1; bus.addr0 = 17'h00000;
      serve(8'h44, 1, a, s, w);
      n_checks++; if (!s || bus.ok0 !== 1'b1 || bus.data0 !== 8'h44) begin n_errors++; $display("FAIL fr_fill0 got ok=%0h d=%0h exp ok=1 d=44", bus.ok0, bus.data0); end
      bus.cs1 = 1'b1; bus.addr1 = 17'h00030;
      tick();
      n_checks++; if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 17'h00030) begin n_errors++; $display("FAIL fr_start got cs=%0h addr=%0h exp cs=1 addr=30", bus.rom_cs, bus.rom_addr); end
      tick();
      bus.rom_ok = 1'b1; bus.rom_data = 8'h99; bus.flush1 = 1'b1;
      tick();
      bus.rom_ok = 1'b0; bus.flush1 = 1'b0;
      n_checks++; if (bus.ok1 !== 1'b0 || bus.data1 !== 8'h99 || bus.rom_cs !== 1'b0) begin n_errors++; $display("FAIL fr_flush got ok1=%0h d=%0h cs=%0h exp ok1=0 d=99 cs=0", bus.ok1, bus.data1, bus.rom_cs); end
      tick();
      n_checks++; if (bus.rom_cs !== 1'b1) begin n_errors++; $display("FAIL fr_refetch got %0h exp 1", bus.rom_cs); end
      rst = 1'b1;
      tick();
      n_checks++; if (bus.rom_cs !== 1'b0 || bus.rom_addr !== '0) begin n_errors++; $display("FAIL fr_rst_rom got cs=%0h addr=%0h exp 0/0", bus.rom_cs, bus.rom_addr); end
      n_checks++; if (bus.ok0 !== 1'b0 || bus.ok1 !== 1'b0 || bus.data1 !== '0) begin n_errors++; $display("FAIL fr_rst_ok got ok0=%0h ok1=%0h d1=%0h exp 0/0/0", bus.ok0, bus.ok1, bus.data1); end
      rst = 1'b0;
      bus.cs0 = 1'b0; bus.cs1 = 1'b0;
   endtask

   task automatic test_random();
      int            hold [2];
      logic          cs_r [2];
      logic [AW-1:0] addr_r [2];
      int            pend [2];
      logic [2:0]    idx;
      int            resp_cnt, resp_lat, hits;
      logic          prev_cs;
      logic [AW-1:0] prev_addr;
      logic          okv;
      logic [DW-1:0] dv;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         hold[i] = 0; cs_r[i] = 1'b0; addr_r[i] = '0; pend[i] = 0;
      end
      resp_cnt = 0; resp_lat = 1; hits = 0;
      prev_cs = 1'b0; prev_addr = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         n_checks++; if (bus.timeout_err !== 1'b0) begin n_errors++; $display("FAIL rnd_terr cyc %0d got 1 exp 0", cyc); end
         if (bus.rom_cs && prev_cs) begin
            n_checks++; if (bus.rom_addr !== prev_addr) begin n_errors++; $display("FAIL rnd_addr_stable cyc %0d got %0h exp %0h", cyc, bus.rom_addr, prev_addr); end
         end
         if (bus.rom_cs && !prev_cs) begin
            resp_cnt = 0;
            resp_lat = $urandom_range(1, 6);
         end
         prev_cs   = bus.rom_cs;
         prev_addr = bus.rom_addr;
         if (!bus.rom_cs) begin
            bus.rom_ok   = 1'($urandom_range(0, 1));
            bus.rom_data = DW'($urandom);
         end else if (resp_cnt == 0) begin
            bus.rom_ok   = 1'($urandom_range(0, 1));
            bus.rom_data = rom_val(bus.rom_addr) ^ 8'hFF;
         end else if (resp_cnt >= resp_lat) begin
            bus.rom_ok   = 1'b1;
            bus.rom_data = rom_val(bus.rom_addr);
         end else begin
            bus.rom_ok   = 1'b0;
            bus.rom_data = DW'($urandom);
         end
         resp_cnt++;
         bus.flush0 = 1'b0;
         bus.flush1 = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (hold[i] == 0) begin
               cs_r[i]   = ($urandom_range(0, 9) < 8);
               idx       = 3'($urandom_range(0, 7));
               addr_r[i] = {idx[2], 14'h0, idx[1:0]};
               hold[i]   = $urandom_range(8, 40);
               pend[i]   = 0;
            end else hold[i]--;
         end
         if ($urandom_range(0, 49) == 0) begin bus.flush0 = 1'b1; pend[0] = 0; end
         if ($urandom_range(0, 49) == 0) begin bus.flush1 = 1'b1; pend[1] = 0; end
         bus.cs0 = cs_r[0]; bus.addr0 = addr_r[0];
         bus.cs1 = cs_r[1]; bus.addr1 = addr_r[1];
         #1;
         for (int i = 0; i < 2; i++) begin
            okv = (i == 0) ? bus.ok0 : bus.ok1;
            dv  = (i == 0) ? bus.data0 : bus.data1;
            if (!cs_r[i]) begin
               n_checks++; if (okv !== 1'b0) begin n_errors++; $display("FAIL rnd_ok_nocs%0d cyc %0d got %0h exp 0", i, cyc, okv); end
            end else if (okv === 1'b1) begin
               hits++;
               pend[i] = 0;
               n_checks++; if (dv !== rom_val(addr_r[i])) begin n_errors++; $display("FAIL rnd_data%0d cyc %0d addr %0h got %0h exp %0h", i, cyc, addr_r[i], dv, rom_val(addr_r[i])); end
            end else begin
               pend[i]++;
               n_checks++; if (pend[i] > 80) begin n_errors++; $display("FAIL rnd_live%0d cyc %0d got %0d waiting exp <=80", i, cyc, pend[i]); pend[i] = 0; end
            end
         end
      end
      n_checks++; if (hits == 0) begin n_errors++; $display("FAIL rnd_hits got 0 exp >0"); end
      bus.rom_ok = 1'b0;
      bus.cs0 = 1'b0; bus.cs1 = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_single_fetch();
      test_contention();
      test_abort();
      test_stale_ok();
      test_timeout();
      test_flush_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/jt7759_rom_arb.md
Name: jt7759_rom_arb

Overview:
- Shares one external ADPCM sample-ROM port between two ROM clients, for example two jt7759 instances on one SDRAM slot.
- Each client sees a private cs/addr/data/ok interface with a one-entry data cache.
- Arbitration is round-robin.
- Requests that are abandoned or stalled are aborted cleanly.
- Sits between the sound-chip ROM interfaces and the board SDRAM/BRAM controller.

Parameters:
AW, 17, address width of the clients and the ROM.
DW, 8, data width.
TOW, 10, width of the timeout counter; a request aborts after 2^TOW-1 cycles in BUSY.

Ports:
clk  input  1  system clock; one clock domain.
rst  input  1  reset; synchronous, active-high.
cs0  input  1  client 0 ROM request.
addr0  input  AW  client 0 address.
flush0  input  1  client 0 cache invalidate.
data0  output  DW  client 0 read data.
ok0  output  1  client 0 data valid for the current addr0.
cs1, addr1, flush1, data1, ok1  same as client 0, for client 1.
rom_cs  output  1  request to the downstream ROM.
rom_addr  output  AW  downstream address.
rom_data  input  DW  downstream data.
rom_ok  input  1  downstream data valid.
timeout_err  output  1  one-cycle pulse when a request times out.

Behaviour:
- Per client i, registered state:
  - valid bit v_i
  - cached address ca_i
  - cached data cd_i
- ok_i = cs_i && v_i && (ca_i == addr_i). This is combinational from the registers and inputs. data_i = cd_i at all times.
- need_i = cs_i && !ok_i.
- Reset, applied synchronously on any clk edge with rst=1, including mid-request:
  - v_i=0, ca_i=0, cd_i=0
  - rom_cs=0, rom_addr=0
  - state=IDLE, gnt=0, last=1 (client 0 wins first), settle=0, timeout counter=0, timeout_err=0
  - ok_i therefore reads 0.
- FSM state IDLE:
  - rom_cs=0.
  - If any need_i: pick a winner.
    - If both clients need service, the client != last wins.
    - Otherwise the single requester wins.
  - On a win: gnt<=winner, rom_addr<=addr_winner, rom_cs<=1, settle<=0, counter<=0, state<=BUSY.
- FSM state BUSY:
  - settle<=1 after the first BUSY cycle.
  - rom_ok is ignored while settle=0. This guards against a stale ok from the previous address.
  - Counter increments every cycle.
  - Completion, on rom_ok && settle:
    - cd_gnt<=rom_data, ca_gnt<=rom_addr, v_gnt<=1
    - rom_cs<=0, last<=gnt, state<=IDLE
  - Abort, when cs_gnt=0 or addr_gnt != rom_addr:
    - rom_cs<=0, state<=IDLE
    - no cache update; last is unchanged
    - Abort has priority over completion in the same cycle.
  - Timeout, when the counter reaches all-ones:
    - rom_cs<=0, timeout_err<=1 for one cycle, state<=IDLE
    - no cache update; last<=gnt
- Back-to-back requests: after completion or abort, rom_cs stays low for at least one cycle (the IDLE cycle), so the downstream always sees a cs falling edge between requests.
- Latency:
  - need_i asserted in IDLE cycle N gives rom_cs=1 at N+1.
  - rom_ok sampled at cycle M (M >= N+2) gives ok_i=1 at M+1.
  - Cache hit: ok_i in the same cycle as addr_i is presented, with zero wait.
- flush_i=1 clears v_i next cycle. If flush_i coincides with completion for client i, cd/ca are written but v_i=0, so flush wins.
- A client that changes addr_i while not granted just sees ok_i drop. Its request is queued by need_i.
- A non-granted client never affects rom_addr.
- Width rules:
  - Address comparisons use the full AW width.
  - The counter is TOW bits and does not wrap: the timeout fires before the counter can overflow.

Test Plan:
- Single fetch: cs0=1, addr0=0x00005; downstream returns rom_ok with rom_data=0x5A three cycles after rom_cs. Required: rom_cs rises 1 cycle after cs0; ok0=1, data0=0x5A one cycle after the settled rom_ok; re-presenting 0x00005 gives ok0 the same cycle with no rom_cs.
- Contention: cs0 and cs1 both rise in the same cycle after reset (addr0=0x10, addr1=0x20). Required: client 0 is served first, then one rom_cs-low cycle, then client 1; a second simultaneous miss serves client 1 last-alternating (client 0 next).
- Abort: client 0 changes addr0 from 0x100 to 0x101 mid-BUSY. Required: rom_cs drops next cycle, cache not updated, then re-arbitration fetches 0x101.
- Stale ok: rom_ok held high continuously. Required: data is captured no earlier than the second BUSY cycle, and the rom_addr in use matches ca0.
- Timeout with TOW=4: rom_ok never asserts. Required: rom_cs is held for 15 cycles, then timeout_err pulses once, and the other pending client is granted next.
- Flush and reset: flush1 in the same cycle as client 1 completion gives ok1=0 afterwards. rst asserted mid-BUSY gives rom_cs=0, rom_addr=0 and ok0=ok1=0 on the next edge.
